// File: rtl/salidas_pkg.sv
// salidas_pkg: shared mode codes, FSM states and bus entry layout for the output stage
package salidas_pkg;
  localparam logic [2:0] MODO_NOP       = 3'b000;
  localparam logic [2:0] MODO_DIRECTO   = 3'b011;
  localparam logic [2:0] MODO_INDIRECTO = 3'b101;
  localparam logic [2:0] MODO_RELATIVO  = 3'b110;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} estado_t;
  localparam int DIR_W_STD  = 8;
  localparam int DATO_W_STD = 8;
  // Default-width view of one FIFO entry; the top packs {dir, dato} in the same order
  typedef struct packed {
    logic [DIR_W_STD-1:0]  dir;
    logic [DATO_W_STD-1:0] dato;
  } entrada_t;
endpackage

// File: rtl/fifo_salidas.sv
// fifo_salidas: synchronous request FIFO with occupancy count and async active-low reset
module fifo_salidas #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
endmodule

// File: rtl/salidas_bus.sv
// salidas_bus: buffers output requests and replays them as strobe/ack bus writes with timeout
module salidas_bus
  import salidas_pkg::*;
#(
  parameter int DATO_W     = 8,
  parameter int DIR_W      = 8,
  parameter int SEL_W      = 3,
  parameter int RY_W       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int TO_CYC     = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              VALIDO,
  output logic              LISTO,
  input  logic [SEL_W-1:0]  SELEC,
  input  logic [DATO_W-1:0] RX_DATO,
  input  logic [RY_W-1:0]   RY,
  input  logic [DATO_W-1:0] RY_DATO,
  output logic [DATO_W-1:0] DATO_OUT,
  output logic [DIR_W-1:0]  DIR_OUT,
  output logic              ESCR,
  input  logic              ACK,
  output logic              OCUPADO,
  output logic              ERR_TO
);
  localparam int CW = $clog2(TO_CYC + 1);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  estado_t                  estado;
  logic [CW-1:0]            cnt;
  logic                     es_dir, es_ind, es_rel;
  logic [DIR_W-1:0]         dir_calc;
  logic                     push, pop, full, empty;
  logic [DIR_W+DATO_W-1:0]  fifo_dout;
  logic [NW-1:0]            fifo_count;
  always_comb begin
    es_dir   = SELEC == SEL_W'(MODO_DIRECTO);
    es_ind   = SELEC == SEL_W'(MODO_INDIRECTO);
    es_rel   = SELEC == SEL_W'(MODO_RELATIVO);
    dir_calc = es_dir ? DIR_W'(RY) :
               es_ind ? DIR_W'(RY_DATO) :
                        DIR_W'(RY_DATO) + DIR_W'(RY);
  end
  assign LISTO   = fifo_count != NW'(FIFO_DEPTH);
  assign push    = VALIDO & ~full & (es_dir | es_ind | es_rel);
  assign pop     = (estado == IDLE || estado == HOLD) & ~empty;
  assign ESCR    = estado == STROBE;
  assign OCUPADO = estado != IDLE || !empty;
  fifo_salidas #(.W(DIR_W + DATO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .pop   (pop),
    .din   ({dir_calc, RX_DATO}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );
  // ACK is checked before the timeout so a coincident acknowledge suppresses ERR_TO
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      estado   <= IDLE;
      cnt      <= '0;
      DIR_OUT  <= '0;
      DATO_OUT <= '0;
      ERR_TO   <= 1'b0;
    end else begin
      ERR_TO <= 1'b0;
      if (pop) {DIR_OUT, DATO_OUT} <= fifo_dout;
      unique case (estado)
        IDLE, HOLD: estado <= empty ? IDLE : SETUP;
        SETUP: begin
          estado <= STROBE;
          cnt    <= '0;
        end
        STROBE: begin
          cnt <= cnt + CW'(1);
          if (ACK) estado <= HOLD;
          else if (cnt == CW'(TO_CYC - 1)) begin
            estado <= HOLD;
            ERR_TO <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_salidas_bus.sv
// tb_salidas_bus: directed checks of request decode, bus handshake, timeout, FIFO full and reset
module tb_salidas_bus;
  import salidas_pkg::*;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       VALIDO = 1'b0;
  logic       LISTO;
  logic [2:0] SELEC = '0;
  logic [7:0] RX_DATO = '0;
  logic [2:0] RY = '0;
  logic [7:0] RY_DATO = '0;
  logic [7:0] DATO_OUT;
  logic [7:0] DIR_OUT;
  logic       ESCR;
  logic       ACK = 1'b0;
  logic       OCUPADO;
  logic       ERR_TO;
  int         n_chk = 0;
  int         n_err = 0;
  logic [15:0] writes [$];
  int          lens [$];
  int          run = 0;
  int          errs = 0;
  logic        escr_prev = 1'b0;
  salidas_bus dut (
    .CLK(CLK), .RST_N(RST_N), .VALIDO(VALIDO), .LISTO(LISTO), .SELEC(SELEC),
    .RX_DATO(RX_DATO), .RY(RY), .RY_DATO(RY_DATO), .DATO_OUT(DATO_OUT),
    .DIR_OUT(DIR_OUT), .ESCR(ESCR), .ACK(ACK), .OCUPADO(OCUPADO), .ERR_TO(ERR_TO)
  );
  always #5 CLK = ~CLK;
  // Bus monitor: logs each write's {dir, dato}, strobe lengths and timeout pulses
  always @(negedge CLK) begin
    if (ESCR && !escr_prev) writes.push_back({DIR_OUT, DATO_OUT});
    if (ESCR) run++;
    else if (escr_prev) begin
      lens.push_back(run);
      run = 0;
    end
    if (ERR_TO) errs++;
    escr_prev = ESCR;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input logic [2:0] s, input logic [7:0] rx, input logic [7:0] ryd, input logic [2:0] ry);
    VALIDO = 1'b1; SELEC = s; RX_DATO = rx; RY_DATO = ryd; RY = ry;
    step();
    VALIDO = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (OCUPADO && n < max) begin
      step();
      n++;
    end
    chk("idle_wait", {31'd0, OCUPADO}, 32'd0);
  endtask
  task automatic clear_log();
    writes.delete();
    lens.delete();
    errs = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(); step();
    chk("rst_dato", DATO_OUT, 0);
    chk("rst_dir", DIR_OUT, 0);
    chk("rst_escr", ESCR, 0);
    chk("rst_err", ERR_TO, 0);
    chk("rst_ocup", OCUPADO, 0);
    chk("rst_listo", LISTO, 1);
    RST_N = 1'b1;
    step();
    // DIRECTO with ACK held high
    ACK = 1'b1;
    clear_log();
    push(MODO_DIRECTO, 8'h55, 8'h00, 3'd6);
    chk("d_ocup_k", OCUPADO, 1);
    chk("d_dir_k", DIR_OUT, 0);
    step();
    chk("d_dir_k1", DIR_OUT, 8'h06);
    chk("d_dato_k1", DATO_OUT, 8'h55);
    chk("d_escr_k1", ESCR, 0);
    step();
    chk("d_escr_k2", ESCR, 1);
    step();
    chk("d_escr_k3", ESCR, 0);
    step();
    chk("d_ocup_k4", OCUPADO, 0);
    chk("d_noerr", errs, 0);
    // INDIRECTO then RELATIVO with 8-bit wrap
    clear_log();
    push(MODO_INDIRECTO, 8'h92, 8'hE3, 3'd2);
    push(MODO_RELATIVO, 8'h3C, 8'hFF, 3'd1);
    wait_idle(30);
    chk("ir_n", writes.size(), 2);
    chk("ir_w0", {16'd0, writes[0]}, 32'hE392);
    chk("ir_w1", {16'd0, writes[1]}, 32'h003C);
    chk("ir_dir_hold", DIR_OUT, 8'h00);
    // Dropped mode codes
    clear_log();
    push(MODO_NOP, 8'h11, 8'h22, 3'd3);
    chk("nop_ocup", OCUPADO, 0);
    push(3'b111, 8'h11, 8'h22, 3'd3);
    chk("m7_ocup", OCUPADO, 0);
    step(); step(); step();
    chk("drop_n", writes.size(), 0);
    chk("drop_ocup", OCUPADO, 0);
    // Timeout on first entry, second entry still written
    clear_log();
    ACK = 1'b0;
    push(MODO_DIRECTO, 8'hA1, 8'h00, 3'd2);
    push(MODO_DIRECTO, 8'hB2, 8'h00, 3'd3);
    for (int i = 0; i < 60 && errs == 0; i++) step();
    chk("to_seen", errs, 1);
    ACK = 1'b1;
    wait_idle(40);
    chk("to_errs", errs, 1);
    chk("to_lens_n", lens.size(), 2);
    chk("to_len0", lens[0], 15);
    chk("to_len1", lens[1], 1);
    chk("to_w0", {16'd0, writes[0]}, 32'h02A1);
    chk("to_w1", {16'd0, writes[1]}, 32'h03B2);
    // FIFO full: fill behind a stalled write, fifth push refused
    clear_log();
    ACK = 1'b0;
    push(MODO_DIRECTO, 8'h10, 8'h00, 3'd0);
    step(); step();
    chk("full_escr", ESCR, 1);
    for (int i = 0; i < 4; i++) begin
      chk("full_listo_pre", LISTO, 1);
      push(MODO_DIRECTO, 8'h20 + 8'(i), 8'h00, 3'(i + 1));
    end
    chk("full_listo4", LISTO, 0);
    push(MODO_DIRECTO, 8'h24, 8'h00, 3'd5);
    chk("full_listo5", LISTO, 0);
    wait_idle(150);
    chk("full_n", writes.size(), 5);
    chk("full_w0", {16'd0, writes[0]}, 32'h0010);
    for (int i = 0; i < 4; i++)
      chk("full_wi", {16'd0, writes[i + 1]}, {16'd0, 8'(i + 1), 8'h20 + 8'(i)});
    chk("full_errs", errs, 5);
    chk("full_listo_end", LISTO, 1);
    // Reset mid-strobe with two entries queued
    push(MODO_DIRECTO, 8'h31, 8'h00, 3'd1);
    push(MODO_DIRECTO, 8'h32, 8'h00, 3'd2);
    push(MODO_DIRECTO, 8'h33, 8'h00, 3'd3);
    chk("mr_escr", ESCR, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mr_escr0", ESCR, 0);
    chk("mr_dir", DIR_OUT, 0);
    chk("mr_dato", DATO_OUT, 0);
    chk("mr_ocup", OCUPADO, 0);
    chk("mr_listo", LISTO, 1);
    chk("mr_err", ERR_TO, 0);
    step(); step();
    #3 RST_N = 1'b1;
    clear_log();
    for (int i = 0; i < 20; i++) step();
    chk("mr_nowr", writes.size(), 0);
    chk("mr_ocup_end", OCUPADO, 0);
    chk("mr_dir_end", DIR_OUT, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
